sobel_mag: RTL and testbench

Downstream stage of the 3×3 window reader in the Sobel path. Takes the eight neighbour pixels (centre omitted), the active-video flag and the VGA syncs. Computes |Gx|+|Gy| in a 3-stage pipeline, saturates to 8 bits and optionally binarises against a threshold. Delays the syncs by the same latency and reports a per-frame count of edge pixels.

---
 rtl/sobel_mag.sv | 131 +++++++++++++
 tb/tb_sobel_mag.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_mag.sv
// Sobel gradient magnitude |Gx|+|Gy| over a 3x3 window: 3-stage pipeline, 8-bit saturation,
// optional thresholding, sync delay lines and a per-frame edge-pixel counter.
module sobel_mag #(
    parameter int unsigned LAT   = 3,
    parameter int unsigned CNT_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       pix_0,
    input  logic [7:0]       pix_1,
    input  logic [7:0]       pix_2,
    input  logic [7:0]       pix_3,
    input  logic [7:0]       pix_5,
    input  logic [7:0]       pix_6,
    input  logic [7:0]       pix_7,
    input  logic [7:0]       pix_8,
    input  logic             act_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [7:0]       thresh,
    input  logic             bin_en,
    output logic [7:0]       edge_out,
    output logic             act_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_valid
);

    logic [9:0] gxp_q, gxn_q, gyp_q, gyn_q;
    logic [9:0] gxp_d, gxn_d, gyp_d, gyn_d;
    logic [9:0] ax_q, ay_q, ax_d, ay_d;
    logic [7:0] edge_q, edge_d;

    logic [LAT-1:0] act_sr_q, hs_sr_q, vs_sr_q;
    logic           vs_prev_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             cnt_valid_q;

    logic [10:0] mag;
    logic [7:0]  sat;
    logic        act_s3;
    logic        hit;
    logic        vs_fall;

    // Stage 1: weighted column/row sums, all unsigned
    always_comb begin
        gxp_d = {2'b00, pix_2} + {1'b0, pix_5, 1'b0} + {2'b00, pix_8};
        gxn_d = {2'b00, pix_0} + {1'b0, pix_3, 1'b0} + {2'b00, pix_6};
        gyp_d = {2'b00, pix_6} + {1'b0, pix_7, 1'b0} + {2'b00, pix_8};
        gyn_d = {2'b00, pix_0} + {1'b0, pix_1, 1'b0} + {2'b00, pix_2};
    end

    // Stage 2: absolute differences as larger minus smaller
    always_comb begin
        ax_d = (gxp_q >= gxn_q) ? (gxp_q - gxn_q) : (gxn_q - gxp_q);
        ay_d = (gyp_q >= gyn_q) ? (gyp_q - gyn_q) : (gyn_q - gyp_q);
    end

    // Stage 3: magnitude, saturation and threshold; act_s3 is the act tap aligned with ax/ay
    always_comb begin
        mag    = {1'b0, ax_q} + {1'b0, ay_q};
        sat    = (mag > 11'd255) ? 8'hFF : mag[7:0];
        act_s3 = act_sr_q[LAT-2];
        hit    = act_s3 & (sat >= thresh);
        if (!act_s3) begin
            edge_d = 8'h00;
        end else if (bin_en) begin
            edge_d = hit ? 8'hFF : 8'h00;
        end else begin
            edge_d = sat;
        end
    end

    assign vs_fall = vs_prev_q & ~vs_sr_q[LAT-1];

    always_comb begin
        cnt_d      = cnt_q;
        edge_cnt_d = edge_cnt_q;
        if (vs_fall) begin
            edge_cnt_d = cnt_q;
            cnt_d      = {{(CNT_W-1){1'b0}}, hit};
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gxp_q       <= '0;
            gxn_q       <= '0;
            gyp_q       <= '0;
            gyn_q       <= '0;
            ax_q        <= '0;
            ay_q        <= '0;
            edge_q      <= '0;
            act_sr_q    <= '0;
            hs_sr_q     <= '0;
            vs_sr_q     <= '0;
            vs_prev_q   <= 1'b0;
            cnt_q       <= '0;
            edge_cnt_q  <= '0;
            cnt_valid_q <= 1'b0;
        end else begin
            gxp_q       <= gxp_d;
            gxn_q       <= gxn_d;
            gyp_q       <= gyp_d;
            gyn_q       <= gyn_d;
            ax_q        <= ax_d;
            ay_q        <= ay_d;
            edge_q      <= edge_d;
            act_sr_q    <= {act_sr_q[LAT-2:0], act_in};
            hs_sr_q     <= {hs_sr_q[LAT-2:0], hsync_in};
            vs_sr_q     <= {vs_sr_q[LAT-2:0], vsync_in};
            vs_prev_q   <= vs_sr_q[LAT-1];
            cnt_q       <= cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            cnt_valid_q <= vs_fall;
        end
    end

    assign edge_out  = edge_q;
    assign act_out   = act_sr_q[LAT-1];
    assign hsync_out = hs_sr_q[LAT-1];
    assign vsync_out = vs_sr_q[LAT-1];
    assign edge_cnt  = edge_cnt_q;
    assign cnt_valid = cnt_valid_q;

endmodule

// File: tb/tb_sobel_mag.sv
// Scoreboard bench for sobel_mag: every driven window pushes its expected output, which is
// popped and compared three clocks later along with the frame-counter model.
module tb_sobel_mag;

    localparam int unsigned LAT   = 3;
    localparam int unsigned CNT_W = 19;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [7:0] edge_v;
        logic       act;
        logic       hs;
        logic       vs;
        logic       hit;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       p0, p1, p2, p3, p5, p6, p7, p8;
    logic             act_in, hsync_in, vsync_in;
    logic [7:0]       thresh;
    logic             bin_en;
    logic [7:0]       edge_out;
    logic             act_out, hsync_out, vsync_out;
    logic [CNT_W-1:0] edge_cnt;
    logic             cnt_valid;

    exp_t             sb[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               acc;
    logic [CNT_W-1:0] exp_cnt;
    logic             v1, v2;
    int               pulses;
    string            cur;

    sobel_mag #(.LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_0     (p0),
        .pix_1     (p1),
        .pix_2     (p2),
        .pix_3     (p3),
        .pix_5     (p5),
        .pix_6     (p6),
        .pix_7     (p7),
        .pix_8     (p8),
        .act_in    (act_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .thresh    (thresh),
        .bin_en    (bin_en),
        .edge_out  (edge_out),
        .act_out   (act_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .edge_cnt  (edge_cnt),
        .cnt_valid (cnt_valid)
    );

    always #5 clk = ~clk;

    task automatic set_win(input logic [7:0] a0, a1, a2, a3, a5, a6, a7, a8);
        p0 = a0; p1 = a1; p2 = a2; p3 = a3; p5 = a5; p6 = a6; p7 = a7; p8 = a8;
    endtask

    task automatic reset_model();
        exp_t z;
        z = '{edge_v: 8'd0, act: 1'b0, hs: 1'b0, vs: 1'b0, hit: 1'b0};
        sb.delete();
        sb.push_back(z);
        sb.push_back(z);
        v1 = 1'b0; v2 = 1'b0; acc = 0; exp_cnt = '0;
    endtask

    // Drive the current inputs for one clock, then compare the window issued three clocks ago.
    task automatic step();
        exp_t e, o;
        int gx, gy, mag, sat;
        logic exp_valid;
        gx = (int'(p2) + 2 * int'(p5) + int'(p8)) - (int'(p0) + 2 * int'(p3) + int'(p6));
        gy = (int'(p6) + 2 * int'(p7) + int'(p8)) - (int'(p0) + 2 * int'(p1) + int'(p2));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        mag = gx + gy;
        sat = (mag > 255) ? 255 : mag;
        e.hit    = act_in && (sat >= int'(thresh));
        e.edge_v = !act_in ? 8'd0 : (bin_en ? (e.hit ? 8'd255 : 8'd0) : 8'(sat));
        e.act    = act_in;
        e.hs     = hsync_in;
        e.vs     = vsync_in;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        exp_valid = 1'b0;
        if (v2 && !v1) begin
            exp_cnt   = CNT_W'(acc);
            acc       = o.hit ? 1 : 0;
            exp_valid = 1'b1;
        end else if (o.hit && acc < CMAX) begin
            acc = acc + 1;
        end
        v2 = v1;
        v1 = o.vs;
        if (cnt_valid === 1'b1) pulses++;
        n_checks += 6;
        if (edge_out !== o.edge_v) begin
            n_fail++;
            $display("FAIL %s edge_out got=%0d exp=%0d t=%0t", cur, edge_out, o.edge_v, $time);
        end
        if (act_out !== o.act) begin
            n_fail++;
            $display("FAIL %s act_out got=%b exp=%b t=%0t", cur, act_out, o.act, $time);
        end
        if (hsync_out !== o.hs) begin
            n_fail++;
            $display("FAIL %s hsync_out got=%b exp=%b t=%0t", cur, hsync_out, o.hs, $time);
        end
        if (vsync_out !== o.vs) begin
            n_fail++;
            $display("FAIL %s vsync_out got=%b exp=%b t=%0t", cur, vsync_out, o.vs, $time);
        end
        if (cnt_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL %s cnt_valid got=%b exp=%b t=%0t", cur, cnt_valid, exp_valid, $time);
        end
        if (edge_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s edge_cnt got=%0d exp=%0d t=%0t", cur, edge_cnt, exp_cnt, $time);
        end
    endtask

    task automatic flush();
        act_in = 1'b0;
        set_win(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (LAT) step();
    endtask

    task automatic check_outputs_zero(input string tag);
        n_checks++;
        if ({edge_out, act_out, hsync_out, vsync_out, edge_cnt, cnt_valid} !== '0) begin
            n_fail++;
            $display("FAIL %s outputs got=%h/%b%b%b/%0d/%b exp=all zero", tag,
                     edge_out, act_out, hsync_out, vsync_out, edge_cnt, cnt_valid);
        end
    endtask

    task automatic test_reset();
        cur = "reset";
        rst = 1'b1;
        act_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        thresh = 8'd0; bin_en = 1'b0;
        set_win(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_flat();
        cur = "flat";
        act_in = 1'b1;
        set_win(100, 100, 100, 100, 100, 100, 100, 100);
        repeat (4) step();
        flush();
    endtask

    task automatic test_gx();
        cur = "gx40_mag";
        act_in = 1'b1;
        set_win(0, 0, 10, 0, 10, 0, 0, 10);
        repeat (3) step();
        flush();
        cur = "gx40_thr50";
        thresh = 8'd50; bin_en = 1'b1;
        act_in = 1'b1;
        set_win(0, 0, 10, 0, 10, 0, 0, 10);
        repeat (3) step();
        flush();
        cur = "gx40_thr40";
        thresh = 8'd40;
        act_in = 1'b1;
        set_win(0, 0, 10, 0, 10, 0, 0, 10);
        repeat (3) step();
        flush();
    endtask

    task automatic test_saturation();
        cur = "sat";
        bin_en = 1'b0;
        act_in = 1'b1;
        set_win(0, 0, 255, 0, 255, 0, 0, 255);
        repeat (2) step();
        cur = "sat_inactive";
        act_in = 1'b0;
        repeat (2) step();
        cur = "thresh0_bin";
        thresh = 8'd0; bin_en = 1'b1;
        flush();
        act_in = 1'b1;
        set_win(7, 7, 7, 7, 7, 7, 7, 7);
        repeat (2) step();
        flush();
        thresh = 8'd40;
    endtask

    task automatic test_frame_count();
        cur = "frame_prep";
        bin_en = 1'b1; thresh = 8'd40;
        act_in = 1'b0; vsync_in = 1'b0;
        repeat (5) step();
        vsync_in = 1'b1;
        repeat (5) step();
        pulses = 0;
        cur = "frame5";
        for (int i = 0; i < 10; i++) begin
            act_in = 1'b1;
            if (i % 2 == 0) set_win(0, 0, 10, 0, 10, 0, 0, 10);
            else            set_win(3, 3, 3, 3, 3, 3, 3, 3);
            step();
        end
        act_in = 1'b0; vsync_in = 1'b0;
        set_win(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (8) step();
        n_checks += 2;
        if (edge_cnt !== 19'd5) begin
            n_fail++;
            $display("FAIL frame5 edge_cnt got=%0d exp=5", edge_cnt);
        end
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL frame5 cnt_valid pulses got=%0d exp=1", pulses);
        end
        cur = "frame0";
        vsync_in = 1'b1;
        act_in = 1'b1;
        set_win(50, 50, 50, 50, 50, 50, 50, 50);
        repeat (10) step();
        act_in = 1'b0; vsync_in = 1'b0;
        repeat (8) step();
        n_checks += 2;
        if (edge_cnt !== 19'd0) begin
            n_fail++;
            $display("FAIL frame0 edge_cnt got=%0d exp=0", edge_cnt);
        end
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL frame0 cnt_valid pulses got=%0d exp=2", pulses);
        end
    endtask

    task automatic test_random_sync();
        cur = "random";
        flush();
        thresh = 8'd60; bin_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            act_in   = 1'($urandom);
            hsync_in = 1'($urandom);
            vsync_in = ($urandom_range(0, 7) != 0);
            set_win(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            step();
        end
        hsync_in = 1'b1; vsync_in = 1'b1;
        flush();
    endtask

    task automatic test_reset_midstream();
        cur = "pre_reset";
        thresh = 8'd40; bin_en = 1'b1;
        act_in = 1'b1; vsync_in = 1'b1;
        set_win(0, 0, 200, 0, 200, 0, 0, 200);
        repeat (6) step();
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_held");
        rst = 1'b0;
        reset_model();
        pulses = 0;
        cur = "post_reset";
        act_in = 1'b1;
        set_win(0, 0, 10, 0, 10, 0, 0, 10);
        repeat (3) step();
        set_win(1, 1, 1, 1, 1, 1, 1, 1);
        repeat (2) step();
        act_in = 1'b0;
        repeat (2) step();
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL post_reset early cnt_valid pulses got=%0d exp=0", pulses);
        end
        vsync_in = 1'b0;
        repeat (8) step();
        n_checks += 2;
        if (edge_cnt !== 19'd3) begin
            n_fail++;
            $display("FAIL post_reset edge_cnt got=%0d exp=3", edge_cnt);
        end
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL post_reset cnt_valid pulses got=%0d exp=1", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_gx();
        test_saturation();
        test_frame_count();
        test_random_sync();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
